// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID pipeline register, honouring redirect > flush > stall.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

    function automatic logic in_range(input logic [31:0] addr);
        return addr < MEM_BYTES;
    endfunction

    logic [31:0] pc_r;
    logic        valid_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc_plus4_r;
    logic [31:0] instr_r;
    logic        fault_r;
    logic [31:0] count_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic        valid_next_s;
    logic [31:0] id_pc_next_s;
    logic [31:0] id_pc_plus4_next_s;
    logic [31:0] instr_next_s;
    logic        fault_next_s;
    logic [31:0] count_next_s;

    // Target bits [1:0] are dropped: redirects are forced to word alignment.
    logic unused_target_bits_s;
    assign unused_target_bits_s = &{1'b0, redirect_target[1:0]};

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-state selection with redirect over flush over stall over normal fetch.
    always_comb begin
        pc_next_s          = pc_r;
        valid_next_s       = valid_r;
        id_pc_next_s       = id_pc_r;
        id_pc_plus4_next_s = id_pc_plus4_r;
        instr_next_s       = instr_r;
        fault_next_s       = fault_r;
        count_next_s       = count_r;
        if (redirect_valid) begin
            pc_next_s    = {redirect_target[31:2], 2'b00};
            valid_next_s = 1'b0;
            instr_next_s = NOP_INSTR;
            fault_next_s = 1'b0;
        end else if (flush) begin
            pc_next_s    = pc_plus4_s;
            valid_next_s = 1'b0;
            instr_next_s = NOP_INSTR;
            fault_next_s = 1'b0;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s          = pc_plus4_s;
            valid_next_s       = 1'b1;
            id_pc_next_s       = pc_r;
            id_pc_plus4_next_s = pc_plus4_s;
            count_next_s       = count_r + 32'd1;
            if (in_range(pc_r)) begin
                instr_next_s = imem_instr;
                fault_next_s = 1'b0;
            end else begin
                instr_next_s = NOP_INSTR;
                fault_next_s = 1'b1;
            end
        end
    end

    // PC, IF/ID register and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            valid_r       <= 1'b0;
            id_pc_r       <= 32'h0000_0000;
            id_pc_plus4_r <= 32'h0000_0000;
            instr_r       <= NOP_INSTR;
            fault_r       <= 1'b0;
            count_r       <= 32'h0000_0000;
        end else begin
            pc_r          <= pc_next_s;
            valid_r       <= valid_next_s;
            id_pc_r       <= id_pc_next_s;
            id_pc_plus4_r <= id_pc_plus4_next_s;
            instr_r       <= instr_next_s;
            fault_r       <= fault_next_s;
            count_r       <= count_next_s;
        end
    end

    assign imem_addr      = pc_r;
    assign if_id_valid    = valid_r;
    assign if_id_pc       = id_pc_r;
    assign if_id_pc_plus4 = id_pc_plus4_r;
    assign if_id_instr    = instr_r;
    assign if_id_fault    = fault_r;
    assign fetch_count    = count_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a behavioural instruction memory.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_fault;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    logic [31:0] mem [0:255];

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .MEM_DEPTH(256),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_fault    (if_id_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return junk the DUT must not capture.
    assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic        st;
        logic        fl;
        logic        rv;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_count;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [0:16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, " pc"}, if_id_pc, 32'h0);
        check({tag, " pc_plus4"}, if_id_pc_plus4, 32'h0);
        check({tag, " instr"}, if_id_instr, 32'h0000_0013);
        check({tag, " fault"}, {31'd0, if_id_fault}, 32'd0);
        check({tag, " count"}, fetch_count, 32'd0);
        check({tag, " addr"}, imem_addr, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        //          st    fl    rv    tgt           valid pc            instr          flt   cnt    addr
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h11,        1'b0, 32'd1, 32'h4};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h22,        1'b0, 32'd2, 32'h8};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h22,        1'b0, 32'd2, 32'h8};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'h22,        1'b0, 32'd2, 32'h8};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h33,        1'b0, 32'd3, 32'hC};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        32'h44,        1'b0, 32'd4, 32'h10};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h42,       1'b0, 32'hC,        32'h13,        1'b0, 32'd4, 32'h40};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'hA000_0010, 1'b0, 32'd5, 32'h44};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h44,       32'hA000_0011, 1'b0, 32'd6, 32'h48};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h44,       32'h13,        1'b0, 32'd6, 32'h4C};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h44,       32'h13,        1'b0, 32'd6, 32'h50};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h50,       32'hA000_0014, 1'b0, 32'd7, 32'h54};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h400,      1'b0, 32'h50,       32'h13,        1'b0, 32'd7, 32'h400};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h400,      32'h13,        1'b1, 32'd8, 32'h404};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h400,     32'h13,        1'b0, 32'd8, 32'hFFFF_FFFC};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h13,       1'b1, 32'd9, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h11,        1'b0, 32'd10, 32'h4};

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state("reset");

        for (int i = 0; i < 17; i++) begin
            stall = vecs[i].st;
            flush = vecs[i].fl;
            redirect_valid = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d pc", i), if_id_pc, vecs[i].e_pc);
            check($sformatf("v%0d pc_plus4", i), if_id_pc_plus4, vecs[i].e_pc + 32'd4);
            check($sformatf("v%0d instr", i), if_id_instr, vecs[i].e_instr);
            check($sformatf("v%0d fault", i), {31'd0, if_id_fault}, {31'd0, vecs[i].e_fault});
            check($sformatf("v%0d count", i), fetch_count, vecs[i].e_count);
            check($sformatf("v%0d addr", i), imem_addr, vecs[i].e_addr);
            @(negedge clk);
        end

        // Asynchronous reset between edges must clear everything without a clock.
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset valid", {31'd0, if_id_valid}, 32'd1);
        check("post_reset pc", if_id_pc, 32'h0);
        check("post_reset instr", if_id_instr, 32'h11);
        check("post_reset count", fetch_count, 32'd1);
        check("post_reset addr", imem_addr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
